automatic_garage_door_controller: RTL and testbench

Moore FSM that drives a garage door motor from one push-button (activate) and two end-of-travel limit switches (up_max, down_max).
- From fully closed, activate raises the door until the upper limit.
- From fully open, activate lowers the door until the lower limit.
- Sits between debounced, synchronized switch inputs and the motor driver enables. Inputs are synchronous to clk; the block adds no synchronizers.

---
 rtl/automatic_garage_door_controller.sv | 80 ++++++++
 tb/tb_automatic_garage_door_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/automatic_garage_door_controller.sv
// Garage door motor controller: one push-button plus two limit switches drive up/down motor enables.
// Optional stuck-motion watchdog is enabled by defining GARAGE_TIMEOUT_EN.
module automatic_garage_door_controller #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up_max,
  input  logic down_max,
  input  logic activate,
  output logic up_m,
  output logic down_m
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MV_UP = 2'd1,
    MV_DN = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   timeout_hit;

`ifdef GARAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] move_cnt;

  assign timeout_hit = (move_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A door between limits closes when activated, since closing is the safe default.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!activate)               next_state = IDLE;
        else if (up_max && down_max) next_state = IDLE;
        else if (down_max)           next_state = MV_UP;
        else                         next_state = MV_DN;
      end
      MV_UP: begin
        if (up_max || timeout_hit) next_state = IDLE;
      end
      MV_DN: begin
        if (down_max || timeout_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered alongside the state so they mirror the state register exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      up_m   <= 1'b0;
      down_m <= 1'b0;
    end else begin
      state  <= next_state;
      up_m   <= (next_state == MV_UP);
      down_m <= (next_state == MV_DN);
    end
  end

`ifdef GARAGE_TIMEOUT_EN
  // The counter restarts on every entry into a move and stays cleared while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      move_cnt <= '0;
    end else if (next_state == IDLE || state == IDLE) begin
      move_cnt <= '0;
    end else begin
      move_cnt <= move_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_automatic_garage_door_controller.sv
// Directed self-checking bench for automatic_garage_door_controller (TIMEOUT_CYCLES=8).
// Expectations for the watchdog steps follow GARAGE_TIMEOUT_EN as seen by this file.
module tb_automatic_garage_door_controller;

  logic clk;
  logic rst_n;
  logic up_max;
  logic down_max;
  logic activate;
  logic up_m;
  logic down_m;

  int checks;
  int failures;

  automatic_garage_door_controller #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_max   (up_max),
    .down_max (down_max),
    .activate (activate),
    .up_m     (up_m),
    .down_m   (down_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic apply_stimulus(input logic r, input logic act, input logic up_l, input logic dn_l);
    @(negedge clk);
    rst_n    = r;
    activate = act;
    up_max   = up_l;
    down_max = dn_l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic exp_up, input logic exp_dn);
    checks++;
    assert (up_m === exp_up) else begin
      failures++;
      $error("[TB] FAIL %s up_m observed=%b expected=%b", tag, up_m, exp_up);
    end
    checks++;
    assert (down_m === exp_dn) else begin
      failures++;
      $error("[TB] FAIL %s down_m observed=%b expected=%b", tag, down_m, exp_dn);
    end
  endtask

  initial begin
    logic exp_after_timeout;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    activate = 1'b0;
    up_max   = 1'b0;
    down_max = 1'b0;
`ifdef GARAGE_TIMEOUT_EN
    exp_after_timeout = 1'b0;
`else
    exp_after_timeout = 1'b1;
`endif

    // Reset wins over a valid open request.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
    check_output("reset", 1'b0, 1'b0);

    // Open from closed, hold through travel, stop at upper limit.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check_output("open_start", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check_output("open_hold", 1'b1, 1'b0);
    end
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("open_stop", 1'b0, 1'b0);

    // Close from open, hold, stop at lower limit.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check_output("close_start", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check_output("close_hold", 1'b0, 1'b1);
    end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    check_output("close_stop", 1'b0, 1'b0);

    // Activate is ignored while moving up.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check_output("move_up", 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("act_while_up", 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("act_released", 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("up_limit", 1'b0, 1'b0);

    // Both limits asserted is a sensor fault: stay idle.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
    check_output("fault_1", 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
    check_output("fault_2", 1'b0, 1'b0);

    // Mid-travel activation closes; reset stops the motor mid-motion.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output("mid_close", 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("mid_hold", 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("mid_reset", 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("post_reset", 1'b0, 1'b0);

    // Holding activate reverses direction one edge after the opposite limit is reached.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check_output("rev_close", 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check_output("rev_idle", 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check_output("rev_open", 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("rev_stop", 1'b0, 1'b0);

    // Watchdog: upward move with no upper limit ever seen.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check_output("to_cycle_1", 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check_output("to_moving", 1'b1, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      check_output("to_after_8", exp_after_timeout, 1'b0);
    end
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("to_final", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog simulation time limit exceeded");
    $fatal(1, "[TB] time limit");
  end

endmodule
